cmd_parser: RTL and testbench

//  Host-side protocol decoder; sits between uart_rx and the glitch core inside top.

---
 rtl/cmd_parser.sv | 186 ++++++++++++++++++
 tb/tb_cmd_parser.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_parser.sv
// Host byte-stream decoder: escaped commands drive config registers and strobes,
// length-prefixed frames stream raw bytes into a passthrough FIFO.
module cmd_parser #(
  parameter int         FIFO_DEPTH = 16,
  parameter int         DELAY_W    = 32,
  parameter logic [7:0] WIDTH_RST  = 8'd1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         width_o,
  output logic [7:0]         pulses_o,
  output logic [DELAY_W-1:0] delay_o,
  output logic               soft_rst_o,
  output logic               arm_o,
  output logic               bad_cmd_o,
  output logic [7:0]         pt_data,
  output logic               pt_valid,
  input  logic               pt_rdy,
  output logic               ovf_o
);

  localparam int NB = DELAY_W / 8;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_ARG, S_DATA} state_t;

  state_t               state_q;
  logic [7:0]           rem_q;
  logic [7:0]           tgt_q;
  logic [7:0]           width_q;
  logic [7:0]           pulses_q;
  logic [DELAY_W-1:0]   delay_q;
  logic                 soft_rst_q;
  logic                 arm_q;
  logic                 bad_cmd_q;
  logic                 ovf_q;

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [AW-1:0]        rd_nxt_s;
  logic [AW:0]          count_q;
  logic [AW:0]          count_d;
  logic [7:0]           pt_data_q;
  logic [7:0]           pt_data_d;

  logic                 push_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 push_ok_s;
  logic                 drop_s;
  logic                 tgt_ok_s;

  assign push_s    = rx_valid && (state_q == S_DATA);
  assign pop_s     = (count_q != CNT_ZERO) && pt_rdy;
  assign full_s    = (count_q == CNT_FULL);
  // A pop frees the slot on the same edge, so a full FIFO still accepts the byte.
  assign push_ok_s = push_s && (!full_s || pop_s);
  assign drop_s    = push_s && full_s && !pop_s;
  assign rd_nxt_s  = rd_ptr_q + AW'(1);
  assign tgt_ok_s  = (rx_data == 8'h10) || (rx_data == 8'h11) ||
                     ((rx_data >= 8'h20) && (rx_data < 8'(32 + NB)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= 8'd0;
      tgt_q      <= 8'd0;
      width_q    <= WIDTH_RST;
      pulses_q   <= 8'd0;
      delay_q    <= '0;
      soft_rst_q <= 1'b0;
      arm_q      <= 1'b0;
      bad_cmd_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      soft_rst_q <= 1'b0;
      arm_q      <= 1'b0;
      bad_cmd_q  <= 1'b0;
      if (drop_s) ovf_q <= 1'b1;
      if (rx_valid) begin
        case (state_q)
          S_IDLE: begin
            if (rx_data == 8'h00) begin
              state_q <= S_CMD;
            end else begin
              rem_q   <= rx_data;
              state_q <= S_DATA;
            end
          end
          S_CMD: begin
            state_q <= S_IDLE;
            if (rx_data == 8'hFF) begin
              soft_rst_q <= 1'b1;
              width_q    <= WIDTH_RST;
              pulses_q   <= 8'd0;
              delay_q    <= '0;
              ovf_q      <= 1'b0;
            end else if (rx_data == 8'hFE) begin
              arm_q <= 1'b1;
            end else if (tgt_ok_s) begin
              tgt_q   <= rx_data;
              state_q <= S_ARG;
            end else begin
              bad_cmd_q <= 1'b1;
            end
          end
          S_ARG: begin
            state_q <= S_IDLE;
            if (tgt_q == 8'h10) begin
              width_q <= rx_data;
            end else if (tgt_q == 8'h11) begin
              pulses_q <= rx_data;
            end else begin
              for (int k = 0; k < NB; k++) begin
                if (tgt_q == 8'(32 + k)) delay_q[8*k +: 8] <= rx_data;
              end
            end
          end
          S_DATA: begin
            rem_q <= rem_q - 8'd1;
            if (rem_q == 8'd1) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Head register: bypass the incoming byte whenever it becomes the new head.
  always_comb begin
    pt_data_d = pt_data_q;
    if (count_q == CNT_ZERO) begin
      if (push_ok_s) pt_data_d = rx_data;
      else           pt_data_d = pt_data_q;
    end else if (pop_s) begin
      if (count_q == CNT_ONE) pt_data_d = rx_data;
      else                    pt_data_d = mem_q[rd_nxt_s];
    end else begin
      pt_data_d = pt_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= CNT_ZERO;
      pt_data_q <= 8'd0;
    end else begin
      count_q   <= count_d;
      pt_data_q <= pt_data_d;
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)     rd_ptr_q <= rd_nxt_s;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_ptr_q] <= rx_data;
  end

  assign width_o    = width_q;
  assign pulses_o   = pulses_q;
  assign delay_o    = delay_q;
  assign soft_rst_o = soft_rst_q;
  assign arm_o      = arm_q;
  assign bad_cmd_o  = bad_cmd_q;
  assign ovf_o      = ovf_q;
  assign pt_data    = pt_data_q;
  assign pt_valid   = (count_q != CNT_ZERO);

endmodule

// File: tb/tb_cmd_parser.sv
// Bench for cmd_parser: directed scenarios plus a random frame stream,
// checked against a byte-level protocol model built on a queue.
module tb_cmd_parser;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  width_o, pulses_o, pt_data;
  logic [31:0] delay_o;
  logic        soft_rst_o, arm_o, bad_cmd_o, pt_valid, pt_rdy, ovf_o;

  cmd_parser #(.FIFO_DEPTH(16), .DELAY_W(32), .WIDTH_RST(8'h01)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .width_o(width_o), .pulses_o(pulses_o), .delay_o(delay_o),
    .soft_rst_o(soft_rst_o), .arm_o(arm_o), .bad_cmd_o(bad_cmd_o),
    .pt_data(pt_data), .pt_valid(pt_valid), .pt_rdy(pt_rdy), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Protocol model: remaining frame bytes, pending escape, pending argument target.
  int          m_rem;
  bit          m_esc;
  int          m_target;
  logic [7:0]  m_width, m_pulses;
  logic [31:0] m_delay;
  logic        m_soft, m_arm, m_bad, m_ovf;
  logic [7:0]  m_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  sent_q[$];

  task automatic m_reset();
    m_rem = 0; m_esc = 0; m_target = -1;
    m_width = 8'h01; m_pulses = 8'h00; m_delay = 32'h0;
    m_soft = 0; m_arm = 0; m_bad = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic do_rst();
    rst = 1'b1; rx_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic rdy);
    bit pop;
    rx_valid = v; rx_data = b; pt_rdy = rdy;
    if (pt_valid && rdy) got_q.push_back(pt_data);
    @(posedge clk);
    m_soft = 0; m_arm = 0; m_bad = 0;
    pop = (m_q.size() > 0) && rdy;
    if (pop) void'(m_q.pop_front());
    if (v) begin
      if (m_rem > 0) begin
        if (m_q.size() < 16) m_q.push_back(b);
        else m_ovf = 1;
        m_rem--;
      end else if (m_target >= 0) begin
        if (m_target == 'h10) m_width = b;
        else if (m_target == 'h11) m_pulses = b;
        else m_delay[8*(m_target-'h20) +: 8] = b;
        m_target = -1;
      end else if (m_esc) begin
        m_esc = 0;
        if (b == 8'hFF) begin
          m_soft = 1; m_width = 8'h01; m_pulses = 8'h00; m_delay = 32'h0; m_ovf = 0;
        end else if (b == 8'hFE) m_arm = 1;
        else if (b == 8'h10 || b == 8'h11 || (b >= 8'h20 && b <= 8'h23)) m_target = int'(b);
        else m_bad = 1;
      end else if (b == 8'h00) m_esc = 1;
      else m_rem = int'(b);
    end
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_rst();
    n_checks++;
    if ({width_o, pulses_o, delay_o, soft_rst_o, arm_o, bad_cmd_o, ovf_o, pt_valid} !==
        {8'h01, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got w=%h p=%h d=%h s=%b a=%b b=%b o=%b v=%b, want w=01 p=00 d=0 rest 0",
               width_o, pulses_o, delay_o, soft_rst_o, arm_o, bad_cmd_o, ovf_o, pt_valid);
    end
  endtask

  task automatic test_soft_rst();
    step(1, 8'h00, 0); step(1, 8'h10, 0); step(1, 8'h22, 0);
    step(1, 8'h00, 0); step(1, 8'h21, 0); step(1, 8'h9C, 0);
    step(1, 8'h00, 0); step(1, 8'hFF, 0);
    n_checks++;
    if ({soft_rst_o, width_o, pulses_o, delay_o, pt_valid, arm_o, bad_cmd_o} !==
        {1'b1, 8'h01, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL soft_rst: got s=%b w=%h p=%h d=%h v=%b a=%b b=%b, want s=1 w=01 p=00 d=0 v=0 a=0 b=0",
               soft_rst_o, width_o, pulses_o, delay_o, pt_valid, arm_o, bad_cmd_o);
    end
    step(0, 8'h00, 0);
    n_checks++;
    if (soft_rst_o !== 1'b0) begin
      n_fail++; $display("FAIL soft_rst_len: got %b want 0", soft_rst_o);
    end
  endtask

  task automatic test_reg_writes();
    logic [7:0] b;
    step(1, 8'h00, 0); step(1, 8'h10, 0); step(1, 8'h22, 0);
    step(1, 8'h00, 0); step(1, 8'h11, 0); step(1, 8'h00, 0);
    step(1, 8'h00, 0); step(1, 8'h20, 0); step(1, 8'h32, 0);
    n_checks++;
    if ({width_o, pulses_o, delay_o} !== {8'h22, 8'h00, 32'h32}) begin
      n_fail++;
      $display("FAIL reg_writes: got w=%h p=%h d=%h want w=22 p=00 d=00000032", width_o, pulses_o, delay_o);
    end
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      step(1, 8'h00, 0); step(1, 8'(32 + k), 0); step(1, b, 0);
      n_checks++;
      if (delay_o !== m_delay) begin
        n_fail++; $display("FAIL delay_byte%0d: got %h want %h", k, delay_o, m_delay);
      end
    end
    step(1, 8'h00, 0); step(1, 8'hFE, 0);
    n_checks++;
    if ({arm_o, bad_cmd_o} !== 2'b10) begin
      n_fail++; $display("FAIL reg_writes_idle: got arm=%b bad=%b want arm=1 bad=0", arm_o, bad_cmd_o);
    end
  endtask

  task automatic test_passthrough();
    logic [7:0] exp_seq [5];
    exp_seq = '{8'hFF, 8'h55, 8'h00, 8'hAA, 8'h00};
    got_q.delete();
    step(1, 8'h05, 1);
    for (int i = 0; i < 5; i++) step(1, exp_seq[i], 1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1);
    n_checks++;
    if (got_q.size() != 5) begin
      n_fail++; $display("FAIL pt_count: got %0d bytes want 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (got_q[i] !== exp_seq[i]) begin
          n_fail++; $display("FAIL pt_byte%0d: got %h want %h", i, got_q[i], exp_seq[i]);
        end
      end
    end
    step(1, 8'h00, 1); step(1, 8'hFE, 1);
    n_checks++;
    if ({arm_o, bad_cmd_o, soft_rst_o} !== 3'b100) begin
      n_fail++; $display("FAIL pt_then_arm: got arm=%b bad=%b soft=%b want 1 0 0", arm_o, bad_cmd_o, soft_rst_o);
    end
    step(0, 8'h00, 1);
    n_checks++;
    if (arm_o !== 1'b0) begin
      n_fail++; $display("FAIL arm_len: got %b want 0", arm_o);
    end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] w0;
    w0 = m_width;
    step(1, 8'h00, 0); step(1, 8'h37, 0);
    n_checks++;
    if ({bad_cmd_o, arm_o, soft_rst_o, width_o, pulses_o, delay_o, pt_valid} !==
        {1'b1, 1'b0, 1'b0, w0, m_pulses, m_delay, 1'b0}) begin
      n_fail++;
      $display("FAIL bad_cmd: got b=%b a=%b s=%b w=%h p=%h d=%h v=%b want b=1 w=%h p=%h d=%h",
               bad_cmd_o, arm_o, soft_rst_o, width_o, pulses_o, delay_o, pt_valid, w0, m_pulses, m_delay);
    end
    step(1, 8'h00, 0);
    n_checks++;
    if (bad_cmd_o !== 1'b0) begin
      n_fail++; $display("FAIL bad_cmd_len: got %b want 0", bad_cmd_o);
    end
    step(1, 8'h10, 0); step(1, 8'h5A, 0);
    n_checks++;
    if (width_o !== 8'h5A) begin
      n_fail++; $display("FAIL fresh_escape: got width %h want 5a", width_o);
    end
    step(1, 8'h00, 0); step(1, 8'h24, 0);
    n_checks++;
    if (bad_cmd_o !== 1'b1) begin
      n_fail++; $display("FAIL delay_range: got bad=%b want 1", bad_cmd_o);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    sent_q.delete(); got_q.delete();
    step(1, 8'd20, 0);
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom); sent_q.push_back(b); step(1, b, 0);
    end
    n_checks++;
    if ({ovf_o, pt_valid} !== 2'b11) begin
      n_fail++; $display("FAIL ovf_set: got ovf=%b valid=%b want 1 1", ovf_o, pt_valid);
    end
    for (int i = 0; i < 18; i++) step(0, 8'h00, 1);
    n_checks++;
    if (got_q.size() != 16 || pt_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_drain: got %0d bytes valid=%b want 16 bytes valid=0", got_q.size(), pt_valid);
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (got_q[i] !== sent_q[i]) begin
          n_fail++; $display("FAIL ovf_byte%0d: got %h want %h", i, got_q[i], sent_q[i]);
        end
      end
    end
    step(1, 8'h00, 0); step(1, 8'hFE, 0);
    n_checks++;
    if ({arm_o, ovf_o} !== 2'b11) begin
      n_fail++; $display("FAIL ovf_idle: got arm=%b ovf=%b want 1 1", arm_o, ovf_o);
    end
    step(1, 8'h00, 0); step(1, 8'hFF, 0);
    n_checks++;
    if (ovf_o !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b want 0", ovf_o);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] b;
    sent_q.delete(); got_q.delete();
    step(1, 8'd17, 0);
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom); sent_q.push_back(b); step(1, b, (i == 16) ? 1'b1 : 1'b0);
    end
    n_checks++;
    if ({ovf_o, pt_valid} !== 2'b01) begin
      n_fail++; $display("FAIL full_push_pop: got ovf=%b valid=%b want 0 1", ovf_o, pt_valid);
    end
    for (int i = 0; i < 18; i++) step(0, 8'h00, 1);
    n_checks++;
    if (got_q.size() != 17) begin
      n_fail++; $display("FAIL full_pp_count: got %0d want 17", got_q.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        n_checks++;
        if (got_q[i] !== sent_q[i]) begin
          n_fail++; $display("FAIL full_pp_byte%0d: got %h want %h", i, got_q[i], sent_q[i]);
        end
      end
    end
  endtask

  task automatic test_mid_rst();
    step(1, 8'h00, 0); step(1, 8'h10, 0); step(1, 8'h77, 0);
    step(1, 8'h02, 0); step(1, 8'hAA, 0);
    do_rst();
    n_checks++;
    if ({pt_valid, width_o, ovf_o} !== {1'b0, 8'h01, 1'b0}) begin
      n_fail++; $display("FAIL mid_rst: got valid=%b width=%h ovf=%b want 0 01 0", pt_valid, width_o, ovf_o);
    end
    got_q.delete();
    step(1, 8'h03, 0); step(1, 8'h00, 0); step(1, 8'h00, 0); step(1, 8'h11, 0);
    step(1, 8'h00, 0); step(1, 8'hFE, 0);
    n_checks++;
    if ({arm_o, pulses_o} !== {1'b1, 8'h00}) begin
      n_fail++; $display("FAIL mid_rst_frame: got arm=%b pulses=%h want 1 00", arm_o, pulses_o);
    end
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1);
    n_checks++;
    if (got_q.size() != 3 || got_q[2] !== 8'h11) begin
      n_fail++; $display("FAIL mid_rst_drain: got %0d bytes want 3 ending in 11", got_q.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] cmds [11];
    logic [7:0] c;
    int len;
    cmds = '{8'hFF, 8'hFE, 8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h37, 8'h00};
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 1) == 0) begin
        c = cmds[$urandom_range(0, 10)];
        step(1, 8'h00, 1'($urandom));
        step(1, c, 1'($urandom));
        if (m_target >= 0) step(1, 8'($urandom), 1'($urandom));
      end else begin
        len = $urandom_range(1, 12);
        step(1, 8'(len), 1'($urandom));
        for (int i = 0; i < len; i++) step(1, 8'($urandom), ($urandom_range(0, 3) == 0));
      end
      if ($urandom_range(0, 2) == 0) step(0, 8'h00, 1'($urandom));
      n_checks++;
      if ({width_o, pulses_o, delay_o, soft_rst_o, arm_o, bad_cmd_o, ovf_o, pt_valid} !==
          {m_width, m_pulses, m_delay, m_soft, m_arm, m_bad, m_ovf, (m_q.size() != 0)}) begin
        n_fail++;
        $display("FAIL random_f%0d: got w=%h p=%h d=%h s%b a%b b%b o%b v%b want w=%h p=%h d=%h s%b a%b b%b o%b v%b",
                 f, width_o, pulses_o, delay_o, soft_rst_o, arm_o, bad_cmd_o, ovf_o, pt_valid,
                 m_width, m_pulses, m_delay, m_soft, m_arm, m_bad, m_ovf, (m_q.size() != 0));
      end
      if (m_q.size() != 0) begin
        n_checks++;
        if (pt_data !== m_q[0]) begin
          n_fail++; $display("FAIL random_head_f%0d: got %h want %h", f, pt_data, m_q[0]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; pt_rdy = 1'b0;
    #2;
    test_reset();
    test_soft_rst();
    test_reg_writes();
    test_passthrough();
    test_bad_cmd();
    test_overflow();
    test_full_push_pop();
    test_mid_rst();
    do_rst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
